program_loader: RTL and testbench

- Writer side of the instruction memory that the single-cycle processor reads from.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at sequential word addresses.
- Holds the processor in reset until the load completes cleanly.

---
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Instruction-memory loader: framed byte stream in, little-endian words out.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        HDR,
        DATA,
        WRITE_LAST,
        DONE,
        ERR
`ifdef LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    localparam logic [31:0] MAX_N = 32'(1) << ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]              n_q, n_d;
    logic [7:0]              wcnt_q, wcnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [23:0]             acc_q, acc_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic xfer;
    assign xfer = rx_valid & rx_ready_q;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        // Advance past a mid-frame write; the final write keeps its address.
        if (we_q && state_q == DATA) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            HDR: begin
                if (xfer) begin
                    n_d    = rx_data;
                    wcnt_d = '0;
                    idx_d  = '0;
                    addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (rx_data == 8'd0) begin
                        state_d = AFTER_DATA;
                    end else if ({24'd0, rx_data} > MAX_N) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    case (idx_q)
                        2'd0: acc_d[7:0]   = rx_data;
                        2'd1: acc_d[15:8]  = rx_data;
                        2'd2: acc_d[23:16] = rx_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {rx_data, acc_q};
                            wcnt_d  = wcnt_q + 8'd1;
                            if (wcnt_d == n_q) begin
                                state_d = WRITE_LAST;
                            end
                        end
                    endcase
                end
            end
            WRITE_LAST: begin
                state_d = AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (reload) begin
                    state_d = HDR;
                    addr_d  = '0;
                    n_d     = '0;
                    wcnt_d  = '0;
                    idx_d   = '0;
                    acc_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase

        rx_ready_d = (state_d == HDR) || (state_d == DATA);
`ifdef LOADER_CHECKSUM_EN
        rx_ready_d = rx_ready_d || (state_d == CSUM);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HDR;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_q        <= '0;
            wcnt_q     <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            n_q        <= n_d;
            wcnt_q     <= wcnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboard of expected memory writes
// plus per-scenario status checks.
module tb_program_loader;

    localparam int AW = 6;
`ifdef LOADER_CHECKSUM_EN
    localparam int EXP_STALLS = 1;
`else
    localparam int EXP_STALLS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          reload = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    int stalls = 0;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;
    logic [7:0]     frame[$];

    program_loader #(
        .ADDR_WIDTH(AW),
        .WORD_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .reload(reload),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_write addr=%0d data=%h",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e) begin
                    bad++;
                    $display("FAIL write got=%0d/%h exp=%0d/%h",
                             imem_addr, imem_wdata,
                             mon_e[AW+31:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic push_exp(input int a, input logic [31:0] d);
        exp_q.push_back({a[AW-1:0], d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        total++;
        if (!rx_ready) begin
            bad++;
            $display("FAIL handshake_timeout byte=%h", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0) cs = cs ^ frame[i];
            send(frame[i], gap);
        end
`ifdef LOADER_CHECKSUM_EN
        send(cs, gap);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total += 7;
        if (rx_ready !== 1'b0) begin
            bad++; $display("FAIL rst_ready got=%b exp=0", rx_ready);
        end
        if (imem_we !== 1'b0) begin
            bad++; $display("FAIL rst_we got=%b exp=0", imem_we);
        end
        if (imem_addr !== '0) begin
            bad++; $display("FAIL rst_addr got=%0d exp=0", imem_addr);
        end
        if (imem_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata);
        end
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL rst_hold got=%b exp=1", cpu_hold);
        end
        if (done !== 1'b0) begin
            bad++; $display("FAIL rst_done got=%b exp=0", done);
        end
        if (error !== 1'b0) begin
            bad++; $display("FAIL rst_error got=%b exp=0", error);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (rx_ready !== 1'b1) begin
            bad++; $display("FAIL post_rst_ready got=%b exp=1", rx_ready);
        end
    endtask

    task automatic check_done(input string tag, input int w0, input int nw);
        total += 5;
        if (done !== 1'b1) begin
            bad++; $display("FAIL %s_done got=%b exp=1", tag, done);
        end
        if (cpu_hold !== 1'b0) begin
            bad++; $display("FAIL %s_hold got=%b exp=0", tag, cpu_hold);
        end
        if (rx_ready !== 1'b0) begin
            bad++; $display("FAIL %s_ready got=%b exp=0", tag, rx_ready);
        end
        if (wr_seen - w0 != nw) begin
            bad++;
            $display("FAIL %s_writes got=%0d exp=%0d", tag, wr_seen - w0, nw);
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d exp=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        do_reset();
        w0 = wr_seen;
        stalls = 0;
        push_exp(0, 32'h00000013);
        push_exp(1, 32'h00100093);
        frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(0);
        repeat (4) @(negedge clk);
        check_done("b2b", w0, 2);
        total++;
        if (stalls != EXP_STALLS) begin
            bad++;
            $display("FAIL b2b_stalls got=%0d exp=%0d", stalls, EXP_STALLS);
        end
    endtask

    task automatic test_gaps();
        int w0;
        do_reset();
        w0 = wr_seen;
        push_exp(0, 32'h00000013);
        push_exp(1, 32'h00100093);
        frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(5);
        repeat (4) @(negedge clk);
        check_done("gaps", w0, 2);
    endtask

    task automatic test_oversize();
        int w0;
        do_reset();
        w0 = wr_seen;
        send(8'h41, 0);
        repeat (3) @(negedge clk);
        total += 5;
        if (error !== 1'b1) begin
            bad++; $display("FAIL big_error got=%b exp=1", error);
        end
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL big_hold got=%b exp=1", cpu_hold);
        end
        if (done !== 1'b0) begin
            bad++; $display("FAIL big_done got=%b exp=0", done);
        end
        if (rx_ready !== 1'b0) begin
            bad++; $display("FAIL big_ready got=%b exp=0", rx_ready);
        end
        if (wr_seen != w0) begin
            bad++; $display("FAIL big_writes got=%0d exp=0", wr_seen - w0);
        end
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        total += 3;
        if (error !== 1'b0) begin
            bad++; $display("FAIL reload_error got=%b exp=0", error);
        end
        if (rx_ready !== 1'b1) begin
            bad++; $display("FAIL reload_ready got=%b exp=1", rx_ready);
        end
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL reload_hold got=%b exp=1", cpu_hold);
        end
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        do_reset();
        w0 = wr_seen;
        send(8'h01, 0);
        send(8'h6F, 0);
        send(8'h00, 0);
        reset = 1'b0;
        #1;
        total += 5;
        if (rx_ready !== 1'b0) begin
            bad++; $display("FAIL mid_ready got=%b exp=0", rx_ready);
        end
        if (imem_we !== 1'b0) begin
            bad++; $display("FAIL mid_we got=%b exp=0", imem_we);
        end
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL mid_hold got=%b exp=1", cpu_hold);
        end
        if (imem_addr !== '0) begin
            bad++; $display("FAIL mid_addr got=%0d exp=0", imem_addr);
        end
        if (wr_seen != w0) begin
            bad++; $display("FAIL mid_writes got=%0d exp=0", wr_seen - w0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_exp(0, 32'h0000006F);
        frame = '{8'h01, 8'h6F, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        repeat (4) @(negedge clk);
        check_done("fresh", w0, 1);
    endtask

    task automatic test_zero_header();
        int w0;
        do_reset();
        w0 = wr_seen;
        frame = '{8'h00};
        send_frame(0);
        repeat (3) @(negedge clk);
        check_done("zero", w0, 0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int w0;
        do_reset();
        w0 = wr_seen;
        push_exp(0, 32'h00000013);
        send(8'h01, 0); send(8'h13, 0); send(8'h00, 0);
        send(8'h00, 0); send(8'h00, 0); send(8'h13, 0);
        repeat (3) @(negedge clk);
        check_done("csum_ok", w0, 1);
        do_reset();
        push_exp(0, 32'h00000013);
        send(8'h01, 0); send(8'h13, 0); send(8'h00, 0);
        send(8'h00, 0); send(8'h00, 0); send(8'h14, 0);
        repeat (3) @(negedge clk);
        total += 3;
        if (error !== 1'b1) begin
            bad++; $display("FAIL csum_bad_error got=%b exp=1", error);
        end
        if (cpu_hold !== 1'b1) begin
            bad++; $display("FAIL csum_bad_hold got=%b exp=1", cpu_hold);
        end
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL csum_bad_pending got=%0d", exp_q.size());
            exp_q.delete();
        end
        do_reset();
        send(8'h00, 0);
        send(8'h01, 0);
        repeat (3) @(negedge clk);
        total++;
        if (error !== 1'b1) begin
            bad++; $display("FAIL csum_zero_error got=%b exp=1", error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_oversize();
        test_reset_mid_frame();
        test_zero_header();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
